// File: rtl/mac_accumulator_pkg.sv
// Shared accelerator definitions for the MAC accumulator: default widths,
// FSM encoding and the saturation bounds of the default result width.
package mac_accumulator_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ACC_W_DEF   = 16;
  localparam int unsigned CNT_W_DEF   = 8;
  // Guard bits on the pre-clamp sum so acc + prod can never wrap.
  localparam int unsigned SAT_GUARD_W = 2;

  localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = 16'sh7FFF;
  localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = 16'sh8000;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// Operand/result stream bundle between an operand source and the MAC accumulator.
interface mac_accumulator_if
  import mac_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_sat;
  logic [CNT_W-1:0]         out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );

endinterface

// File: rtl/sat_clamp.sv
// Signed clamp from IN_W to OUT_W bits; shared by the accumulator and requant stage.
module sat_clamp #(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout_c,
  output logic                    sat_c
);

  logic [IN_W-OUT_W:0] upper;
  logic                fits;

  // Value fits when every bit above the output MSB equals the output sign bit.
  assign upper = din[IN_W-1:OUT_W-1];
  assign fits  = (&upper) | ~(|upper);
  assign sat_c = ~fits;

  always_comb begin
    dout_c = din[OUT_W-1:0];
    if (!fits) begin
      dout_c = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate with per-beat saturation; holds each dot-product
// result until the downstream handshake, then restarts from zero.
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  mac_accumulator_if.slave bus
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + SAT_GUARD_W;

  mac_state_e              state;
  logic signed [ACC_W-1:0] acc;
  logic                    sat;
  logic [CNT_W-1:0]        count;
  logic                    in_ready_q;
  logic                    out_valid_q;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [SUM_W-1:0]  sum_c;
  logic signed [ACC_W-1:0]  clamp_c;
  logic                     clamp_sat_c;
  logic                     accept_c;

  assign accept_c = bus.in_valid && in_ready_q;
  assign prod_c   = PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
  assign sum_c    = SUM_W'(acc) + SUM_W'(prod_c);

  sat_clamp #(
    .IN_W  (SUM_W),
    .OUT_W (ACC_W)
  ) u_clamp (
    .din    (sum_c),
    .dout_c (clamp_c),
    .sat_c  (clamp_sat_c)
  );

  // ACCUM/HOLD control with registered handshake outputs; clr beats everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      sat         <= 1'b0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state       <= ACCUM;
      acc         <= '0;
      sat         <= 1'b0;
      count       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept_c) begin
            acc <= clamp_c;
            sat <= sat | clamp_sat_c;
            if (count != {CNT_W{1'b1}}) begin
              count <= count + CNT_W'(1);
            end
            if (bus.in_last) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            acc         <= '0;
            sat         <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc;
  assign bus.out_sat   = sat;
  assign bus.out_count = count;

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: vector table plus handwritten
// sequences for backpressure, clr, counter saturation and async reset.
module tb_mac_accumulator;
  import mac_accumulator_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  mac_accumulator_if bus ();

  mac_accumulator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [15:0] data;
    logic        sat;
    logic [7:0]  count;
  } exp_t;

  typedef struct {
    int   n;
    int   a[5];
    int   b[5];
    exp_t exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Presents one beat at a negedge and returns at the negedge after acceptance.
  task automatic drive_beat(input int a, input int b, input bit last);
    int w;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'(a);
    bus.in_b     = 8'(b);
    bus.in_last  = last;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_result(input string name);
    int   w;
    exp_t e;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_data"},  32'($unsigned(bus.out_data)), 32'(e.data));
      check({name, "_sat"},   32'(bus.out_sat), 32'(e.sat));
      check({name, "_count"}, 32'(bus.out_count), 32'(e.count));
    end
  endtask

  task automatic handshake(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, "_hs_in_ready"},  32'(bus.in_ready), 32'd1);
    check({name, "_hs_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_hs_count"},     32'(bus.out_count), 32'd0);
    check({name, "_hs_data"},      32'($unsigned(bus.out_data)), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    for (int i = 0; i < v.n; i++) begin
      if (i == v.n - 1) sb.push_back(v.exp);
      drive_beat(v.a[i], v.b[i], i == v.n - 1);
      if (i != v.n - 1) check({name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
    end
    check({name, "_latency"}, 32'(bus.out_valid), 32'd1);
    expect_result(name);
    handshake(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0].n = 4; vecs[0].a = '{1, 3, -5, 7, 0};       vecs[0].b = '{2, 4, 6, -8, 0};
    vecs[0].exp = '{16'hFFB8, 1'b0, 8'd4};
    vecs[1].n = 3; vecs[1].a = '{127, 127, 127, 0, 0};  vecs[1].b = '{127, 127, 127, 0, 0};
    vecs[1].exp = '{ACC_MAX, 1'b1, 8'd3};
    vecs[2].n = 3; vecs[2].a = '{-128, -128, -128, 0, 0}; vecs[2].b = '{127, 127, 127, 0, 0};
    vecs[2].exp = '{ACC_MIN, 1'b1, 8'd3};
    vecs[3].n = 1; vecs[3].a = '{-128, 0, 0, 0, 0};     vecs[3].b = '{-128, 0, 0, 0, 0};
    vecs[3].exp = '{16'h4000, 1'b0, 8'd1};
    // Clamp high, then continue from 32767: 32767 - 16256 = 16511
    vecs[4].n = 4; vecs[4].a = '{127, 127, 127, -128, 0}; vecs[4].b = '{127, 127, 127, 127, 0};
    vecs[4].exp = '{16'h407F, 1'b1, 8'd4};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",      32'($unsigned(bus.out_data)), 32'd0);
    check("rst_count",     32'(bus.out_count), 32'd0);
    check("rst_sat",       32'(bus.out_sat), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Backpressure: 2*3 + 4*5 = 26 held for five cycles
    sb.push_back('{16'h001A, 1'b0, 8'd2});
    drive_beat(2, 3, 1'b0);
    drive_beat(4, 5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_data",      32'($unsigned(bus.out_data)), 32'h001A);
      check("bp_count",     32'(bus.out_count), 32'd2);
      check("bp_in_ready",  32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    expect_result("bp");
    handshake("bp");

    // clr with a simultaneous last beat drops the beat and the result
    drive_beat(10, 10, 1'b0);
    drive_beat(20, 20, 1'b0);
    clr = 1'b1;
    drive_beat(5, 5, 1'b1);
    clr = 1'b0;
    check("clr_out_valid", 32'(bus.out_valid), 32'd0);
    check("clr_data",      32'($unsigned(bus.out_data)), 32'd0);
    check("clr_count",     32'(bus.out_count), 32'd0);
    check("clr_in_ready",  32'(bus.in_ready), 32'd1);
    sb.push_back('{16'h4000, 1'b0, 8'd1});
    drive_beat(-128, -128, 1'b1);
    expect_result("clr_next");
    handshake("clr_next");

    // clr overrides an output handshake in HOLD
    drive_beat(3, 3, 1'b1);
    check("clrh_pre_valid", 32'(bus.out_valid), 32'd1);
    clr = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.out_ready = 1'b0;
    check("clrh_out_valid", 32'(bus.out_valid), 32'd0);
    check("clrh_data",      32'($unsigned(bus.out_data)), 32'd0);
    check("clrh_in_ready",  32'(bus.in_ready), 32'd1);

    // Counter saturates at 255 while acc keeps summing to 300
    sb.push_back('{16'h012C, 1'b0, 8'hFF});
    for (int i = 0; i < 300; i++) drive_beat(1, 1, i == 299);
    expect_result("cnt_sat");
    handshake("cnt_sat");

    // Async reset mid-vector
    drive_beat(50, 50, 1'b0);
    drive_beat(60, 60, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("arst_mid_data",  32'($unsigned(bus.out_data)), 32'd0);
    check("arst_mid_count", 32'(bus.out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Async reset while holding a result
    drive_beat(7, 7, 1'b1);
    check("arst_hold_pre", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_valid", 32'(bus.out_valid), 32'd0);
    check("arst_hold_data",  32'($unsigned(bus.out_data)), 32'd0);
    check("arst_hold_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], "after_arst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
